// File: rtl/fetch_stage.sv
// Instruction fetch stage: a PC register feeding a combinational instruction
// memory, with a small prefetch queue between fetch and decode. A redirect
// flushes the queue and restarts fetching at the redirect target.
module fetch_stage #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 5,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [AW-1:0]              imem_addr,
    input  logic [31:0]                imem_inst,
    input  logic                       redirect,
    input  logic [AW-1:0]              redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [AW-1:0]              out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] START_PC = AW'(RESET_PC);

    logic [AW-1:0] pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    logic full;
    logic push;
    logic pop;

    // Handshake decode: fullness is judged on the occupancy at the start of
    // the cycle, so a same-cycle pop never frees room for a push.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        push      = fetch_en && !redirect && !full;
        out_valid = (count_q != '0) && !redirect;
        pop       = out_valid && out_ready;
    end

    assign imem_addr = pc;
    assign out_inst  = inst_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
    assign count     = count_q;

    // Control state: PC, queue pointers and occupancy; redirect wins over all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= START_PC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            pc      <= redirect_pc;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                pc     <= pc + AW'(1);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage written at the tail on every push.
    // NOTE: the entry arrays carry no reset; an entry is only ever read after
    // a push has written it, and occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_inst;
            pc_mem[wr_ptr]   <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fetch_stage;

    localparam int DEPTH    = 4;
    localparam int AW       = 5;
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int RESET_PC = 0;

    logic          clk;
    logic          rst;
    logic          fetch_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_inst;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [AW-1:0] out_pc;
    logic [CW-1:0] count;

    logic [31:0] imem [2**AW];

    // Reference model: pending entries as {pc, inst}, plus the fetch address.
    logic [AW+31:0] q [$];
    logic [AW-1:0]  mpc;

    int checks = 0;
    int errors = 0;
    logic [31:0] held_inst;

    fetch_stage #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .imem_addr   (imem_addr),
        .imem_inst   (imem_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .count       (count)
    );

    assign imem_inst = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic exp_valid;
        exp_valid = (q.size() != 0) && !redirect;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("count", 64'(count), 64'(q.size()));
        check("imem_addr", 64'(imem_addr), 64'(mpc));
        if (exp_valid) begin
            check("out_pc", 64'(out_pc), 64'(q[0][AW+31:32]));
            check("out_inst", 64'(out_inst), 64'(q[0][31:0]));
        end
    endtask

    task automatic advance_model();
        int size0;
        size0 = q.size();
        if (redirect) begin
            q.delete();
            mpc = redirect_pc;
        end else begin
            if (size0 != 0 && out_ready) void'(q.pop_front());
            if (fetch_en && size0 < DEPTH) begin
                q.push_back({mpc, imem[mpc]});
                mpc = mpc + 1'b1;
            end
        end
    endtask

    // One clock cycle: drive, compare just after settling, then step model and DUT.
    task automatic cycle(input logic fe, input logic rd, input logic [AW-1:0] rdpc, input logic rdy);
        fetch_en    = fe;
        redirect    = rd;
        redirect_pc = rdpc;
        out_ready   = rdy;
        #1;
        compare_outputs();
        advance_model();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset between edges, check its immediate effect, release at the next negedge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));
        q.delete();
        mpc = AW'(RESET_PC);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        for (int i = 0; i < 2**AW; i++) imem[i] = $urandom;
        q.delete();
        mpc = AW'(RESET_PC);
        @(negedge clk);
        do_reset();

        // Fill: no consumer, queue saturates at DEPTH and fetching stops.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_pc", 64'(imem_addr), 64'd4);
        check("fill_out_pc", 64'(out_pc), 64'd0);

        // Backpressure: bring head to pc 2, stall three cycles, then release.
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        held_inst = out_inst;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        check("bp_out_pc", 64'(out_pc), 64'd2);
        check("bp_out_inst", 64'(out_inst), 64'(held_inst));
        check("bp_inst_mem", 64'(out_inst), 64'(imem[2]));
        check("bp_count", 64'(count), 64'd4);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("bp_advance", 64'(out_pc), 64'd3);

        // Streaming from reset: one instruction per cycle, occupancy stays 1.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b1);
        check("stream_count", 64'(count), 64'd1);
        check("stream_out_pc", 64'(out_pc), 64'd7);

        // Redirect with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        check("redir_pre_count", 64'(count), 64'd3);
        cycle(1'b1, 1'b1, AW'(16), 1'b0);
        check("redir_count", 64'(count), 64'd0);
        check("redir_addr", 64'(imem_addr), 64'd16);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check("redir_valid", 64'(out_valid), 64'd1);
        check("redir_out_pc", 64'(out_pc), 64'd16);

        // Wrap: redirect to the top address, stream across 2^AW-1 -> 0.
        cycle(1'b1, 1'b1, AW'(31), 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("wrap_pc31", 64'(out_pc), 64'd31);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("wrap_pc0", 64'(out_pc), 64'd0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("wrap_pc1", 64'(out_pc), 64'd1);

        // Asynchronous reset landing mid-cycle with two entries queued.
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check("areset_pre_count", 64'(count), 64'd2);
        do_reset();

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cycle(($urandom % 8) != 0, ($urandom % 10) == 0, AW'($urandom), 1'($urandom % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the prefetch queue depth in entries (power of two, >=2).
REQ-002 SHALL have parameter AW, default 5, the instruction word-address width.
REQ-003 SHALL have parameter RESET_PC, default 0, the word address fetched first after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port fetch_en  input  1  fetch enable; low holds the PC and suppresses pushes.
REQ-007 SHALL have port imem_addr  output  AW  word address to the combinational instruction memory.
REQ-008 SHALL have port imem_inst  input  32  instruction returned for imem_addr in the same cycle.
REQ-009 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  AW  word address of the redirect target.
REQ-011 SHALL have port out_valid  output  1  head queue entry is valid for decode.
REQ-012 SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-013 SHALL have port out_inst  output  32  head entry instruction.
REQ-014 SHALL have port out_pc  output  AW  head entry word address.
REQ-015 SHALL have port count  output  clog2(DEPTH+1)  current queue occupancy.

Function
REQ-016 SHALL drive imem_addr combinationally from the internal PC register.
REQ-017 SHALL push {pc, imem_inst} at the tail and increment pc by 1 when fetch_en=1, redirect=0 and count<DEPTH at the start of the cycle.
REQ-018 SHALL NOT push when count=DEPTH, even if a pop occurs in the same cycle.
REQ-019 SHALL wrap pc modulo 2^AW (pc=2^AW-1 increments to 0).
REQ-020 SHALL drive out_valid = (count!=0) AND NOT redirect.
REQ-021 SHALL pop the head entry when out_valid=1 and out_ready=1.
REQ-022 SHALL leave count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-023 SHALL hold out_inst and out_pc stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on redirect=1, set count to 0, reset the read and write pointers, load pc with redirect_pc, and suppress both push and pop in that cycle.
REQ-025 SHALL give redirect priority over fetch_en, push and pop.
REQ-026 SHALL, on the first cycle after a redirect, fetch redirect_pc, so that out_pc=redirect_pc with out_valid=1 one further cycle later.
REQ-027 SHALL present out_inst/out_pc as don't-care when out_valid=0.
REQ-028 SHALL have a first-push-to-out_valid latency of one cycle and sustain one instruction per cycle when out_ready is held high.

Reset
REQ-029 SHALL, while rst=0, immediately and asynchronously set pc=RESET_PC, count=0, the read and write pointers to 0, and out_valid=0.
REQ-030 SHALL discard all queued entries and any in-progress push or pop when reset asserts mid-operation.
REQ-031 SHALL begin fetching RESET_PC on the first rising clk edge after rst deasserts, with fetch_en=1.

Verification
REQ-032 Fill test: DEPTH=4, reset release, fetch_en=1, out_ready=0 for 6 cycles -> count reaches 4 after 4 edges; pc=4; out_pc=0; no further pushes.
REQ-033 Streaming test: out_ready=1 from reset -> out_pc sequence 0,1,2,3,... with one per cycle; count stays 1; out_inst matches memory contents.
REQ-034 Redirect test: count=3 and redirect=1 with redirect_pc=0x10 -> out_valid=0 that cycle; next cycle count=0 and imem_addr=0x10; following cycle out_valid=1 and out_pc=0x10.
REQ-035 Wrap test: redirect_pc=31 (AW=5) with streaming -> out_pc sequence 31,0,1.
REQ-036 Backpressure test: out_valid=1, out_pc=2, out_ready=0 for 3 cycles -> out_pc=2 and out_inst unchanged; count saturates at 4; out_ready=1 -> out_pc advances to 3.
REQ-037 Async reset test: rst driven low between clock edges with count=2 -> out_valid=0, count=0, imem_addr=RESET_PC before the next edge.
